// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory line port between the I-cache and D-cache.
// Optional saturating grant/conflict counters are enabled with CACHE_ARB_PERF_CNT_EN.
module cache_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_pmem_read,
  input  logic [ADDR_W-1:0] icache_pmem_address,
  output logic              icache_pmem_resp,
  output logic [LINE_W-1:0] icache_pmem_rdata,
  input  logic              dcache_pmem_read,
  input  logic              dcache_pmem_write,
  input  logic [ADDR_W-1:0] dcache_pmem_address,
  input  logic [LINE_W-1:0] dcache_pmem_wdata,
  output logic              dcache_pmem_resp,
  output logic [LINE_W-1:0] dcache_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
`ifdef CACHE_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_igrants,
  output logic [31:0]       perf_dgrants,
  output logic [31:0]       perf_conflicts
`endif
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t              state_reg, state_next;
  logic                last_grant_reg, last_grant_next;  // 1 = D-cache won last
  logic                op_write_reg, op_write_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [LINE_W-1:0]   wdata_reg, wdata_next;

  logic idle, i_req, d_req, grant_i, grant_d;

  assign idle  = (state_reg == IDLE);
  assign i_req = icache_pmem_read;
  assign d_req = dcache_pmem_read | dcache_pmem_write;
  // On a tie the side that did not win last time takes the port.
  assign grant_i = idle & i_req & (~d_req | last_grant_reg);
  assign grant_d = idle & d_req & ~grant_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      op_write_reg   <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      op_write_reg   <= op_write_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    last_grant_next  = last_grant_reg;
    op_write_next    = op_write_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    icache_pmem_resp = 1'b0;
    dcache_pmem_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_i) begin
          state_next      = I_BUSY;
          last_grant_next = 1'b0;
          op_write_next   = 1'b0;
          addr_next       = icache_pmem_address;
        end else if (grant_d) begin
          state_next      = D_BUSY;
          last_grant_next = 1'b1;
          // A simultaneous read and write is illegal; the read wins.
          op_write_next   = dcache_pmem_write & ~dcache_pmem_read;
          addr_next       = dcache_pmem_address;
          wdata_next      = dcache_pmem_wdata;
        end
      end
      I_BUSY: begin
        pmem_read        = 1'b1;
        icache_pmem_resp = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      D_BUSY: begin
        pmem_read        = ~op_write_reg;
        pmem_write       = op_write_reg;
        dcache_pmem_resp = pmem_resp;
        if (pmem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign pmem_address      = addr_reg;
  assign pmem_wdata        = wdata_reg;
  assign icache_pmem_rdata = pmem_rdata;
  assign dcache_pmem_rdata = pmem_rdata;

`ifdef CACHE_ARB_PERF_CNT_EN
  logic [2:0] perf_inc;
  assign perf_inc = {idle & i_req & d_req, grant_d, grant_i};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      logic [31:0] cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_reg <= '0;
        else if (perf_inc[gi] && (cnt_reg != '1))
          cnt_reg <= cnt_reg + 32'd1;
      end
    end
  endgenerate

  assign perf_igrants   = g_perf[0].cnt_reg;
  assign perf_dgrants   = g_perf[1].cnt_reg;
  assign perf_conflicts = g_perf[2].cnt_reg;
`endif

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory line port between the instruction cache and the data cache of the pipelined LC-3b.
- Sits between the two L1 cache controllers and the memory/L2 port.
- Grants one requester at a time, latches its address and data, and forwards the memory response to that requester.
- Resolves simultaneous requests round-robin, so neither fetch nor MEM stage starves.

Parameters:
- ADDR_W, 16, byte address width.
- LINE_W, 128, cache line width in bits.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- icache_pmem_read  in  1  I-cache line read request, held until icache_pmem_resp.
- icache_pmem_address  in  ADDR_W  I-cache line address.
- icache_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- icache_pmem_rdata  out  LINE_W  line data to I-cache, valid with resp.
- dcache_pmem_read  in  1  D-cache line read request, held until resp.
- dcache_pmem_write  in  1  D-cache line write-back request, held until resp.
- dcache_pmem_address  in  ADDR_W  D-cache line address.
- dcache_pmem_wdata  in  LINE_W  write-back line.
- dcache_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- dcache_pmem_rdata  out  LINE_W  line data to D-cache, valid with resp.
- pmem_read  out  1  memory read strobe, held until pmem_resp.
- pmem_write  out  1  memory write strobe, held until pmem_resp.
- pmem_address  out  ADDR_W  latched transaction address.
- pmem_wdata  out  LINE_W  latched write data.
- pmem_resp  in  1  memory completion pulse.
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp.

Behaviour:
- FSM states: IDLE, I_BUSY, D_BUSY. Also holds last_grant (I/D), addr_q, wdata_q and op_q (read/write).
- Reset: state=IDLE, last_grant=D, addr_q=0, wdata_q=0. All outputs 0.
- IDLE: pmem_read=pmem_write=0; pmem_address/pmem_wdata show addr_q/wdata_q.
  - I request only -> I_BUSY.
  - D request only -> D_BUSY.
  - Both requesting -> grant the requester not equal to last_grant.
  - On grant, latch address, wdata and op; set last_grant to the winner.
- I_BUSY: pmem_read=1, pmem_write=0.
- D_BUSY: pmem_read or pmem_write per op_q.
  - dcache read and write both high at grant is illegal; read takes precedence.
- In a BUSY state, pmem_resp=1 -> the granted side's *_pmem_resp=1 the same cycle (combinational). *_rdata=pmem_rdata. Next state is IDLE.
- The other side's resp is always 0. Both rdata outputs may mirror pmem_rdata at all times.
- Latency:
  - Request seen in IDLE at edge N -> pmem strobe in cycle N+1.
  - At least one IDLE cycle between consecutive transactions, so the requester can drop its request after resp.
- Requester deasserts mid-transaction: ignored. Transaction completes from latched values; the response pulse is still delivered.
- pmem_resp while IDLE: ignored, no resp forwarded.
- A new request from the non-granted side during BUSY waits; it is arbitrated in the next IDLE.
- D-cache write-back then fill: two separate transactions. If the I-cache is waiting, it is granted between them (round-robin).
- Reset asserted mid-transaction: immediate return to IDLE with all strobes 0. The outstanding memory transaction is abandoned; the memory model must tolerate this.

Optional Feature:
- Macro: CACHE_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_igrants, perf_dgrants, perf_conflicts (32 bits each).
  - Each increments on I grant, D grant, and each IDLE cycle with both requests high, respectively.
  - Counters saturate at all-ones and reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then icache_pmem_read=1, addr 0x1230 -> pmem_read=1, pmem_address=0x1230 one cycle later. Memory returns 0xDEAD…BEEF with pmem_resp -> icache_pmem_resp pulses once with that data; dcache_pmem_resp stays 0.
- dcache_pmem_write=1, addr 0x4000, wdata 0xA5…A5 -> pmem_write=1 with that address and data. pmem_read=0 throughout; dcache_pmem_resp pulses on pmem_resp.
- Both request in the same cycle after reset -> I granted first (last_grant=D). D granted in the IDLE following I's resp. With continuous dual requests, grants alternate I,D,I,D.
- Requester drops request mid-transaction, memory responds after 5 cycles -> pmem strobe held for all 5 cycles with latched address unchanged; resp still delivered.
- Assert rst during D_BUSY -> pmem_write=0 immediately (asynchronous). After release, the FSM is in IDLE; a stray pmem_resp produces no *_resp.
- With CACHE_ARB_PERF_CNT_EN: 3 I grants, 2 D grants, 1 conflict cycle -> counters read 3/2/1.
